// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline registers.
// Handles data-cache miss freezes, load-use bubbles, branch flushes and perf counters.
module pipeline_stall_controller #(
  parameter int MISS_PENALTY = 4,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hitOut,
  input  logic             MemReadOut,
  input  logic             MemWriteOut,
  input  logic             BranchOut,
  input  logic             zeroFlagOut,
  input  logic             memReady,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Write,
  output logic             missStall,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] missCount
);

  localparam int CNT_BITS = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MISS_PENALTY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    RESUME = 2'd2
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cntNext;
  logic                memAcc;
  logic                missNow;
  logic                taken;
  logic                loadUse;
  logic                missEvent;

  assign memAcc  = MemReadOut | MemWriteOut;
  assign missNow = (state == IDLE) & memAcc & ~hitOut;
  assign taken   = BranchOut & zeroFlagOut;
  assign loadUse = ID_EX_MemRead & (ID_EX_rt != 5'd0) &
                   ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    missEvent = 1'b0;
    case (state)
      IDLE: begin
        if (missNow) begin
          nextState = MISS;
          cntNext   = CNT_LOAD;
          missEvent = 1'b1;
        end
      end
      MISS: begin
        if (cnt != '0) begin
          cntNext = cnt - 1'b1;
        end else if (memReady) begin
          nextState = RESUME;
        end
      end
      RESUME: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Miss freeze dominates; RESUME skips miss detection so the refilled access completes.
  always_comb begin
    PCWrite      = 1'b1;
    PCSrc        = 1'b0;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Write = 1'b1;
    missStall    = 1'b0;
    if (RST) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (state == MISS || missNow) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      missStall    = 1'b1;
    end else if (taken) begin
      PCSrc        = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (loadUse) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stallCycles <= '0;
      missCount   <= '0;
    end else begin
      if (!PCWrite && (stallCycles != '1)) begin
        stallCycles <= stallCycles + 1'b1;
      end
      if (missEvent && (missCount != '1)) begin
        missCount <= missCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized scoreboard bench for pipeline_stall_controller against a cycle-level
// reference model of the stall/flush rules.
module tb_pipeline_stall_controller;

  localparam int PEN    = 4;
  localparam int CW     = 4;
  localparam int SATMAX = (1 << CW) - 1;

  // Control vector: PCWrite,PCSrc,IF_ID_Write,IF_ID_Flush,ID_EX_Flush,EX_MEM_Write,EX_MEM_Flush,MEM_WB_Write,missStall
  localparam logic [8:0] V_RESET  = 9'b000110100;
  localparam logic [8:0] V_STALL  = 9'b000000001;
  localparam logic [8:0] V_BRANCH = 9'b111111110;
  localparam logic [8:0] V_LOADU  = 9'b000011010;
  localparam logic [8:0] V_NORMAL = 9'b101001010;

  typedef struct {
    logic [8:0] ctrl;
    int         stall;
    int         miss;
  } expT;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          hitOut = 1'b1;
  logic          MemReadOut = 1'b0;
  logic          MemWriteOut = 1'b0;
  logic          BranchOut = 1'b0;
  logic          zeroFlagOut = 1'b0;
  logic          memReady = 1'b0;
  logic          ID_EX_MemRead = 1'b0;
  logic [4:0]    ID_EX_rt = 5'd0;
  logic [4:0]    IF_ID_rs = 5'd0;
  logic [4:0]    IF_ID_rt = 5'd0;
  logic          PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic          EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, missStall;
  logic [CW-1:0] stallCycles, missCount;

  expT sbq[$];
  int  checks = 0;
  int  errors = 0;

  bit  mInMiss = 0;
  bit  mResume = 0;
  int  mWait = 0;
  int  mStall = 0;
  int  mMiss = 0;

  pipeline_stall_controller #(.MISS_PENALTY(PEN), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .hitOut(hitOut), .MemReadOut(MemReadOut),
    .MemWriteOut(MemWriteOut), .BranchOut(BranchOut), .zeroFlagOut(zeroFlagOut),
    .memReady(memReady), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .EX_MEM_Flush(EX_MEM_Flush),
    .MEM_WB_Write(MEM_WB_Write), .missStall(missStall),
    .stallCycles(stallCycles), .missCount(missCount)
  );

  always #5 CLK = ~CLK;

  // Drives one cycle of inputs, predicts that cycle's outputs, then advances the model past the edge.
  task automatic applyStimulus(input bit r, input bit hit, input bit mr, input bit mw,
                               input bit br, input bit z, input bit rdy, input bit idMr,
                               input logic [4:0] idRt, input logic [4:0] rs,
                               input logic [4:0] rt);
    expT e;
    bit  taken, lu, missNow;
    @(posedge CLK);
    #1;
    RST = r; hitOut = hit; MemReadOut = mr; MemWriteOut = mw; BranchOut = br;
    zeroFlagOut = z; memReady = rdy; ID_EX_MemRead = idMr; ID_EX_rt = idRt;
    IF_ID_rs = rs; IF_ID_rt = rt;
    taken   = br && z;
    lu      = idMr && (idRt != 5'd0) && ((idRt == rs) || (idRt == rt));
    missNow = !r && !mInMiss && !mResume && (mr || mw) && !hit;
    if (r) e.ctrl = V_RESET;
    else if (mInMiss || missNow) e.ctrl = V_STALL;
    else if (taken) e.ctrl = V_BRANCH;
    else if (lu) e.ctrl = V_LOADU;
    else e.ctrl = V_NORMAL;
    e.stall = mStall;
    e.miss  = mMiss;
    sbq.push_back(e);
    if (r) begin
      mInMiss = 0; mResume = 0; mWait = 0; mStall = 0; mMiss = 0;
    end else begin
      if (!e.ctrl[8] && mStall < SATMAX) mStall++;
      if (mInMiss) begin
        if (mWait > 0) mWait--;
        else if (rdy) begin
          mInMiss = 0;
          mResume = 1;
        end
      end else if (missNow) begin
        mInMiss = 1;
        mWait   = PEN - 1;
        if (mMiss < SATMAX) mMiss++;
      end else begin
        mResume = 0;
      end
    end
  endtask

  task automatic checkOutput(input expT e);
    logic [8:0] act;
    act = {PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write, missStall};
    checks++;
    if (act !== e.ctrl) begin
      errors++;
      $display("[TB] FAIL ctrl at %0t: got %b expected %b", $time, act, e.ctrl);
    end
    checks++;
    if (int'(stallCycles) != e.stall) begin
      errors++;
      $display("[TB] FAIL stallCycles at %0t: got %0d expected %0d", $time, stallCycles, e.stall);
    end
    checks++;
    if (int'(missCount) != e.miss) begin
      errors++;
      $display("[TB] FAIL missCount at %0t: got %0d expected %0d", $time, missCount, e.miss);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one expectation is consumed per falling edge.
  initial begin
    expT e;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    $display("[TB] Starting pipeline_stall_controller bench");
    // Reset for two cycles, then idle.
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Load miss with memory immediately ready; hitOut stays low into RESUME.
    repeat (7) applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    // Late refill: memReady held low past the penalty.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    repeat (7) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    // Load-use, then the same with r0 as destination.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd7);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd6, 5'd1, 5'd6);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    // Store miss with a taken branch and load-use held in the frozen registers.
    repeat (6) applyStimulus(0, 0, 0, 1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Reset asserted mid-miss.
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Twenty back-to-back misses drive both counters into saturation.
    repeat (20 * (PEN + 2)) applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    repeat (3) applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 5'd2, 5'd2, 5'd0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                    $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
    end
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Freezes the pipeline for a fixed miss penalty when the MEM-stage access misses the data cache. Also handles load-use hazards and branch flushes.
- Keeps saturating stall and miss performance counters.
- Sits beside the pipeline registers. Consumes EX_MEM outputs plus hazard fields from IF_ID and ID_EX. Drives all write enables and flushes.

Parameters:
- MISS_PENALTY, 4: minimum cycles spent in MISS per data-cache miss (≥1).
- CNT_W, 16: width of performance counters.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous active-high reset
- hitOut  input  1  data-cache hit for current EX_MEM access
- MemReadOut  input  1  EX_MEM load
- MemWriteOut  input  1  EX_MEM store
- BranchOut  input  1  EX_MEM branch
- zeroFlagOut  input  1  EX_MEM zero flag
- memReady  input  1  refill complete from memory
- ID_EX_MemRead  input  1  ID_EX load
- ID_EX_rt  input  5  ID_EX destination register of load
- IF_ID_rs  input  5  IF_ID source register rs
- IF_ID_rt  input  5  IF_ID source register rt
- PCWrite  output  1  PC update enable
- PCSrc  output  1  1 = select branchTarget
- IF_ID_Write  output  1  IF_ID load enable
- IF_ID_Flush  output  1  IF_ID clear to NOP
- ID_EX_Flush  output  1  ID_EX clear control bits (bubble)
- EX_MEM_Write  output  1  EX_MEM load enable
- EX_MEM_Flush  output  1  EX_MEM clear control bits
- MEM_WB_Write  output  1  MEM_WB load enable
- missStall  output  1  high while a miss stall is in effect
- stallCycles  output  CNT_W  saturating count of cycles with PCWrite=0
- missCount  output  CNT_W  saturating count of misses

Behaviour:
- FSM states are IDLE, MISS, RESUME. State, down-counter cnt and perf counters are registers. All control outputs are combinational from state and inputs (Mealy).
- memAcc = MemReadOut | MemWriteOut. missNow = (state==IDLE) & memAcc & ~hitOut.
- taken = BranchOut & zeroFlagOut.
- loadUse = ID_EX_MemRead & (ID_EX_rt!=0) & (ID_EX_rt==IF_ID_rs | ID_EX_rt==IF_ID_rt).

Reset:
- While RST=1: state→IDLE, cnt→0, stallCycles→0, missCount→0.
- Outputs during reset: PCWrite=IF_ID_Write=EX_MEM_Write=MEM_WB_Write=0; IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1; PCSrc=0; missStall=0.
- Reset mid-MISS aborts the stall immediately; the first cycle after reset is IDLE.

IDLE:
- missNow=1:
  - missStall=1; all *_Write=0; all flushes=0; PCSrc=0.
  - Next state MISS, cnt←MISS_PENALTY-1, missCount++.
- Else if taken:
  - PCWrite=1, PCSrc=1; IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1; other writes=1.
  - Branch overrides loadUse.
- Else if loadUse:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; EX_MEM_Write=MEM_WB_Write=1.
- Else: all writes=1, flushes=0, PCSrc=0.

MISS:
- missStall=1; all *_Write=0; all flushes=0; PCSrc=0.
- taken and loadUse are ignored; frozen registers hold the branch for re-evaluation.
- cnt≠0: cnt--.
- cnt==0 & memReady: next RESUME.
- cnt==0 & ~memReady: stay, cnt holds 0.
- memReady before cnt==0 has no effect.
- MISS_PENALTY=1: exit is possible on the first MISS cycle.

RESUME (exactly 1 cycle):
- hitOut is ignored; the access is treated as satisfied.
- missStall=0. Outputs follow the IDLE rules excluding missNow (taken > loadUse > normal).
- Next state IDLE.
- A new miss can only be detected the cycle after RESUME.

Counters:
- stallCycles increments on every non-reset cycle with PCWrite=0 (miss or load-use).
- Both counters saturate at all-ones; no wrap.

Simultaneous events:
- missNow with taken or loadUse: the miss wins.
- Branch/load-use are evaluated in RESUME, not at the miss cycle.

Test Plan:
- Reset: RST=1 two cycles then 0, idle inputs → during RST writes 0 and flushes 1. After RST: PCWrite=1, stallCycles=0, missCount=0.
- Miss, MISS_PENALTY=4: MemReadOut=1, hitOut=0, memReady=1 → missStall high 5 cycles (detect+4 MISS), then RESUME with writes=1 despite hitOut=0. missCount=1, stallCycles=5.
- Late memReady: miss with memReady=0 until 3 cycles after cnt==0 → stall extends to 8 cycles total, exit the cycle after memReady rises.
- Load-use: ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 → PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for that cycle. With ID_EX_rt=0, no stall.
- Branch during miss: MemWriteOut=1, hitOut=0, BranchOut=1, zeroFlagOut=1 → no flush while stalled. In RESUME: PCSrc=1, IF_ID/ID_EX/EX_MEM flushes=1.
- Saturation, CNT_W=4: 20 consecutive misses → missCount holds 15.
